// File: rtl/edge_count_bcd.sv
// edge_count_bcd: counts synchronised rising edges of an asynchronous input
// over a fixed gate window and presents the result as two BCD digits with a
// one-cycle load strobe for the seven-segment display stage.
module edge_count_bcd #(
    parameter int unsigned UPDATE_PERIOD = 1200,
    parameter int unsigned PERIOD_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       load
);

    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(99);
    localparam logic [PERIOD_W-1:0] WIN_LAST = PERIOD_W'(UPDATE_PERIOD - 1);

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        TENS  = 2'd1,
        UNITS = 2'd2,
        LOAD  = 2'd3
    } state_t;

    logic                s1;
    logic                s2;
    logic                s3;
    logic                rise_c;
    logic [PERIOD_W-1:0] win_cnt;
    logic                win_end_c;
    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    snapshot_c;
    logic [CNT_W-1:0]    work;
    logic [3:0]          t_acc;
    state_t              state;

    assign rise_c    = s2 & ~s3;
    assign win_end_c = (win_cnt == WIN_LAST);
    // Closing count includes a rise landing in the window's last cycle, capped at 99.
    assign snapshot_c = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + CNT_W'(rise_c);

    // Three-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= signal;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Free-running gate window counter; windows are back to back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_cnt <= '0;
        end else if (win_end_c) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + PERIOD_W'(1);
        end
    end

    // Saturating edge counter, cleared as each window closes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            edge_cnt <= '0;
        end else if (win_end_c) begin
            edge_cnt <= '0;
        end else if (rise_c && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    // Binary-to-BCD by repeated subtraction of ten, then present and strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= COUNT;
            work  <= '0;
            t_acc <= '0;
            tens  <= '0;
            units <= '0;
            load  <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                COUNT: begin
                    if (win_end_c) begin
                        work  <= snapshot_c;
                        t_acc <= '0;
                        state <= TENS;
                    end
                end
                TENS: begin
                    if (work >= CNT_W'(10)) begin
                        work  <= work - CNT_W'(10);
                        t_acc <= t_acc + 4'd1;
                    end else begin
                        state <= UNITS;
                    end
                end
                UNITS: begin
                    tens  <= t_acc;
                    units <= work[3:0];
                    load  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    state <= COUNT;
                end
                default: begin
                    state <= COUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_count_bcd.sv
// Bench for edge_count_bcd: two instances (100- and 1200-cycle windows)
// checked every cycle against a window-arithmetic model, plus literal
// expectations for the arrival cycle and digits of selected load pulses.
module tb_edge_count_bcd;

    localparam int unsigned P_A = 100;
    localparam int unsigned P_B = 1200;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       sig_a = 1'b0;
    logic       sig_b = 1'b0;
    logic [3:0] tens_a;
    logic [3:0] units_a;
    logic       load_a;
    logic [3:0] tens_b;
    logic [3:0] units_b;
    logic       load_b;

    int checks = 0;
    int errors = 0;
    // Posedges since the last reset posedge; shared by both instances.
    int kc = 0;

    edge_count_bcd #(.UPDATE_PERIOD(P_A), .PERIOD_W(16)) dut_a (
        .clk(clk), .reset(reset), .signal(sig_a),
        .tens(tens_a), .units(units_a), .load(load_a)
    );

    edge_count_bcd #(.UPDATE_PERIOD(P_B), .PERIOD_W(16)) dut_b (
        .clk(clk), .reset(reset), .signal(sig_b),
        .tens(tens_b), .units(units_b), .load(load_b)
    );

    initial forever #5 clk = ~clk;

    // Model state per instance.
    int cnt    [2] = '{0, 0};
    bit p1     [2] = '{1'b0, 1'b0};
    bit p2     [2] = '{1'b0, 1'b0};
    int due    [2] = '{-1, -1};
    int due_t  [2] = '{0, 0};
    int due_u  [2] = '{0, 0};
    bit e_load [2] = '{1'b0, 1'b0};
    int e_t    [2] = '{0, 0};
    int e_u    [2] = '{0, 0};

    function automatic int per(int i);
        return (i == 0) ? int'(P_A) : int'(P_B);
    endfunction

    // Model: per-window edge totals, decimal digits by division, load scheduled
    // at end cycle + tens digit + 3.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                kc = 0;
                for (int i = 0; i < 2; i++) begin
                    cnt[i] = 0; p1[i] = 1'b0; p2[i] = 1'b0; due[i] = -1;
                    e_load[i] = 1'b0; e_t[i] = 0; e_u[i] = 0;
                end
            end else begin
                kc = kc + 1;
                for (int i = 0; i < 2; i++) begin
                    bit r;
                    int total;
                    r = p1[i] & ~p2[i];
                    p2[i] = p1[i];
                    p1[i] = (i == 0) ? sig_a : sig_b;
                    e_load[i] = 1'b0;
                    if (due[i] == kc) begin
                        e_load[i] = 1'b1;
                        e_t[i] = due_t[i];
                        e_u[i] = due_u[i];
                        due[i] = -1;
                    end
                    cnt[i] = cnt[i] + int'(r);
                    if ((kc % per(i)) == per(i) - 1) begin
                        total = (cnt[i] > 99) ? 99 : cnt[i];
                        assert (due[i] == -1) else begin
                            errors++;
                            $display("FAIL window_overrun inst=%0d k=%0d pending=%0d", i, kc, due[i]);
                        end
                        due[i]   = kc + total / 10 + 3;
                        due_t[i] = total / 10;
                        due_u[i] = total % 10;
                        cnt[i]   = 0;
                    end
                end
            end
        end
    end

    task automatic cmp(int i, logic l, logic [3:0] t, logic [3:0] u);
        checks++;
        if (l !== e_load[i] || t !== 4'(e_t[i]) || u !== 4'(e_u[i])) begin
            errors++;
            $display("FAIL model_cmp inst=%0d k=%0d got load=%b tens=%0d units=%0d want load=%b tens=%0d units=%0d",
                     i, kc, l, t, u, e_load[i], e_t[i], e_u[i]);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp(0, load_a, tens_a, units_a);
            cmp(1, load_b, tens_b, units_b);
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_k(int x);
        int g = 0;
        while (kc != x && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (kc != x) begin
            checks++;
            errors++;
            $display("FAIL wait_k_timeout actual=%0d expected=%0d", kc, x);
        end
    endtask

    // Wait for the next load pulse of instance i and check cycle and digits.
    task automatic expect_load(string name, int i, int exp_k, int exp_t, int exp_u, output int k);
        bit ok = 1'b0;
        int c  = 0;
        k = -1;
        while (!ok && c < 400) begin
            @(negedge clk);
            c++;
            if ((i == 0) ? load_a : load_b) begin
                ok = 1'b1;
                k  = kc;
                chk({name, "_cycle"}, kc, exp_k);
                chk({name, "_tens"},  int'((i == 0) ? tens_a  : tens_b),  exp_t);
                chk({name, "_units"}, int'((i == 0) ? units_a : units_b), exp_u);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=none expected=load at k=%0d", name, exp_k);
        end
    endtask

    task automatic pulse_a(int n);
        for (int j = 0; j < n; j++) begin
            sig_a = 1'b1;
            @(negedge clk);
            sig_a = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        int prev_k;
        // Reset held for three cycles with the inputs toggling.
        repeat (3) begin
            @(negedge clk);
            sig_a = ~sig_a;
            sig_b = ~sig_b;
        end
        chk("rst_load_a",  int'(load_a),  0);
        chk("rst_tens_a",  int'(tens_a),  0);
        chk("rst_units_a", int'(units_a), 0);
        chk("rst_load_b",  int'(load_b),  0);
        chk("rst_tens_b",  int'(tens_b),  0);
        chk("rst_units_b", int'(units_b), 0);
        reset = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;

        fork
            begin
                expect_load("w0_idle", 0, 102, 0, 0, k);
                pulse_a(37);
                expect_load("w1_37", 0, 205, 3, 7, k);
                // Rise in the last window cycle belongs to the closing window.
                wait_k(297);
                sig_a = 1'b1;
                expect_load("rise_last_cycle", 0, 302, 0, 1, k);
                sig_a = 1'b0;
                // Rise one cycle after the window end belongs to the new window.
                wait_k(398);
                sig_a = 1'b1;
                expect_load("rise_first_cycle_old", 0, 402, 0, 0, k);
                sig_a = 1'b0;
                expect_load("rise_first_cycle_new", 0, 502, 0, 1, k);
                prev_k = k;
                for (int w = 5; w < 10; w++) begin
                    wait_k(w * 100 + 10);
                    pulse_a(42);
                    expect_load($sformatf("w%0d_42", w), 0, w * 100 + 106, 4, 2, k);
                    if (w > 5) chk("spacing_42", k - prev_k, 100);
                    prev_k = k;
                    @(negedge clk);
                    chk("pulse_width_42", int'(load_a), 0);
                end
                expect_load("w10_zero", 0, 1102, 0, 0, k);
                wait_k(1110);
                pulse_a(13);
                expect_load("w11_13", 0, 1203, 1, 3, k);
            end
            begin
                while (kc < 1198) begin
                    sig_b = ~sig_b;
                    @(negedge clk);
                end
                sig_b = 1'b0;
                expect_load("sat_99", 1, 1211, 9, 9, k);
            end
        join

        // Reset while the converter is working on a count of 25.
        wait_k(1215);
        pulse_a(25);
        wait_k(1301);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_load_a",  int'(load_a),  0);
        chk("midrst_tens_a",  int'(tens_a),  0);
        chk("midrst_units_a", int'(units_a), 0);
        reset = 1'b1;
        wait_k(3);
        pulse_a(19);
        expect_load("post_reset_19", 0, 103, 1, 9, k);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
